// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file.
//   master : decode + writeback side (drives register numbers, reservations, writes)
//   slave  : register file side (returns read data, busy flags, rsv_full, busy_cnt)
//   srcreg1/2_num -> regdata1/2, src1/2_busy  : two read ports with hazard flags
//   rsv_we, rsv_num -> rsv_full               : reservation request and refusal
//   reg_we, dstreg_num, write_value           : writeback (also releases a reservation)
//   busy_cnt                                  : some register still has an outstanding write
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic [AW-1:0]   srcreg1_num;
    logic [AW-1:0]   srcreg2_num;
    logic [XLEN-1:0] regdata1;
    logic [XLEN-1:0] regdata2;
    logic            src1_busy;
    logic            src2_busy;
    logic            rsv_we;
    logic [AW-1:0]   rsv_num;
    logic            rsv_full;
    logic [AW-1:0]   dstreg_num;
    logic [XLEN-1:0] write_value;
    logic            reg_we;
    logic            busy_cnt;

    modport master (
        output srcreg1_num, srcreg2_num, rsv_we, rsv_num, dstreg_num, write_value, reg_we,
        input  regdata1, regdata2, src1_busy, src2_busy, rsv_full, busy_cnt
    );

    modport slave (
        input  srcreg1_num, srcreg2_num, rsv_we, rsv_num, dstreg_num, write_value, reg_we,
        output regdata1, regdata2, src1_busy, src2_busy, rsv_full, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register reservation scoreboard.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; clears all data and counters
//   bus : regfile_sb_if.slave (read ports, reservation port, writeback port, flags)
// Each register carries a CNTW-bit counter of outstanding writes. Decode reserves,
// writeback releases; a nonzero counter marks the register busy.
// Optional macro REGFILE_WB_BYPASS_EN: forward same-cycle writeback data onto the
// read ports and evaluate busy on the post-release counter.

// One register plus its reservation counter.
module regfile_sb_entry #(
    parameter int XLEN = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            inc,
    input  logic            dec,
    output logic [XLEN-1:0] data,
    output logic [CNTW-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else begin
            if (we) data <= wdata;
            // inc is only ever asserted below saturation; inc with dec cancels out,
            // and a release on an idle counter holds at zero.
            if (inc && !dec)
                cnt <= cnt + CNTW'(1);
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - CNTW'(1);
        end
    end
endmodule

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int CNTW     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [NREG-1:0][XLEN-1:0] data;
    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0]           nz;

    logic            full_raw;
    logic            rsv_acc;
    logic            wr_ok;
    logic [XLEN-1:0] rd1, rd2;
    logic            b1, b2;

    // Register 0 is never reserved or written in zero-register mode, so its
    // counter stays 0 and it never reports full or busy.
    assign full_raw = (cnt[bus.rsv_num] == CNT_MAX);
    assign rsv_acc  = bus.rsv_we && !full_raw && !(ZERO_REG != 0 && bus.rsv_num == '0);
    assign wr_ok    = bus.reg_we && !(ZERO_REG != 0 && bus.dstreg_num == '0);

    for (genvar i = 0; i < NREG; i++) begin : g_ent
        regfile_sb_entry #(.XLEN(XLEN), .CNTW(CNTW)) u_ent (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_ok && bus.dstreg_num == AW'(i)),
            .wdata (bus.write_value),
            .inc   (rsv_acc && bus.rsv_num == AW'(i)),
            .dec   (wr_ok && bus.dstreg_num == AW'(i)),
            .data  (data[i]),
            .cnt   (cnt[i])
        );
        assign nz[i] = |cnt[i];
    end

    always_comb begin
        rd1 = (ZERO_REG != 0 && bus.srcreg1_num == '0) ? '0 : data[bus.srcreg1_num];
        rd2 = (ZERO_REG != 0 && bus.srcreg2_num == '0) ? '0 : data[bus.srcreg2_num];
        b1  = nz[bus.srcreg1_num];
        b2  = nz[bus.srcreg2_num];
`ifdef REGFILE_WB_BYPASS_EN
        // Post-release counter is nonzero only if the stored one is above 1;
        // a same-cycle reserve is deliberately not counted here.
        if (wr_ok && bus.dstreg_num == bus.srcreg1_num) begin
            rd1 = bus.write_value;
            b1  = cnt[bus.srcreg1_num] > CNTW'(1);
        end
        if (wr_ok && bus.dstreg_num == bus.srcreg2_num) begin
            rd2 = bus.write_value;
            b2  = cnt[bus.srcreg2_num] > CNTW'(1);
        end
`endif
        // Forwarded write data must not leak out while reset is held.
        if (rst) begin
            rd1 = '0;
            rd2 = '0;
            b1  = 1'b0;
            b2  = 1'b0;
        end
    end

    assign bus.regdata1  = rd1;
    assign bus.regdata2  = rd2;
    assign bus.src1_busy = b1;
    assign bus.src2_busy = b2;
    assign bus.rsv_full  = full_raw && !rst;
    assign bus.busy_cnt  = (|nz) && !rst;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();
    regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  s1, s2;
        logic        rsv_we;
        logic [4:0]  rn;
        logic        reg_we;
        logic [4:0]  dst;
        logic [31:0] wv;
    } in_t;

    typedef struct {
        logic [31:0] rd1, rd2;
        logic        b1, b2, full, bcnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    function automatic vec_t mk(input logic [4:0] s1, input logic [4:0] s2,
                                input logic rw, input logic [4:0] rn,
                                input logic ww, input logic [4:0] dst, input logic [31:0] wv,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic b1, input logic b2, input logic full, input logic bcnt);
        vec_t v;
        v.i.s1 = s1; v.i.s2 = s2; v.i.rsv_we = rw; v.i.rn = rn;
        v.i.reg_we = ww; v.i.dst = dst; v.i.wv = wv;
        v.e.rd1 = rd1; v.e.rd2 = rd2; v.e.b1 = b1; v.e.b2 = b2;
        v.e.full = full; v.e.bcnt = bcnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input in_t x);
        bus.srcreg1_num = x.s1;
        bus.srcreg2_num = x.s2;
        bus.rsv_we      = x.rsv_we;
        bus.rsv_num     = x.rn;
        bus.reg_we      = x.reg_we;
        bus.dstreg_num  = x.dst;
        bus.write_value = x.wv;
    endtask

    // Pop the oldest expectation and compare it against what the DUT shows now.
    task automatic sample(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tot_cnt++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".rd1"},  bus.regdata1,  e.rd1);
        chk({tag, ".rd2"},  bus.regdata2,  e.rd2);
        chk({tag, ".b1"},   32'(bus.src1_busy), 32'(e.b1));
        chk({tag, ".b2"},   32'(bus.src2_busy), 32'(e.b2));
        chk({tag, ".full"}, 32'(bus.rsv_full),  32'(e.full));
        chk({tag, ".bcnt"}, 32'(bus.busy_cnt),  32'(e.bcnt));
    endtask

    task automatic expect_now(input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic b1, input logic b2, input logic full, input logic bcnt);
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 0, rd1, rd2, b1, b2, full, bcnt);
        sb.push_back(v.e);
    endtask

    initial begin
        vec_t v;
        //          s1  s2  rw rn  ww dst wv              rd1                             rd2                   b1    b2    full bcnt
        tbl.push_back(mk(0,  31, 0, 0,  0, 0,  32'h0,        32'h0,                          32'h0,                0,    0,    0, 0));
        tbl.push_back(mk(1,  0,  0, 0,  1, 5,  32'hDEADBEEF, 32'h0,                          32'h0,                0,    0,    0, 0));
        tbl.push_back(mk(5,  0,  0, 0,  1, 0,  32'h12345678, 32'hDEADBEEF,                   32'h0,                0,    0,    0, 0));
        tbl.push_back(mk(0,  5,  1, 0,  0, 0,  32'h0,        32'h0,                          32'hDEADBEEF,         0,    0,    0, 0));
        tbl.push_back(mk(0,  5,  0, 0,  0, 0,  32'h0,        32'h0,                          32'hDEADBEEF,         0,    0,    0, 0));
        // reservation lifecycle on reg 7
        tbl.push_back(mk(7,  0,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                0,    0,    0, 0));
        tbl.push_back(mk(7,  0,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                1,    0,    0, 1));
        tbl.push_back(mk(7,  0,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                1,    0,    0, 1));
        tbl.push_back(mk(7,  0,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                1,    0,    1, 1));
        tbl.push_back(mk(7,  0,  0, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                1,    0,    1, 1));
        // saturated: reserve refused, release applied -> 2
        tbl.push_back(mk(7,  0,  1, 7,  1, 7,  32'h71,       BYP ? 32'h71 : 32'h0,           32'h0,                1,    0,    1, 1));
        tbl.push_back(mk(7,  0,  0, 7,  1, 7,  32'h72,       BYP ? 32'h72 : 32'h71,          32'h0,                1,    0,    0, 1));
        tbl.push_back(mk(7,  0,  0, 7,  1, 7,  32'h73,       BYP ? 32'h73 : 32'h72,          32'h0,                !BYP, 0,    0, 1));
        tbl.push_back(mk(7,  0,  0, 7,  0, 0,  32'h0,        32'h73,                         32'h0,                0,    0,    0, 0));
        // simultaneous reserve/release
        tbl.push_back(mk(9,  0,  1, 9,  0, 0,  32'h0,        32'h0,                          32'h0,                0,    0,    0, 0));
        tbl.push_back(mk(9,  0,  1, 9,  1, 9,  32'h99,       BYP ? 32'h99 : 32'h0,           32'h0,                !BYP, 0,    0, 1));
        tbl.push_back(mk(9,  0,  0, 9,  0, 0,  32'h0,        32'h99,                         32'h0,                1,    0,    0, 1));
        tbl.push_back(mk(3,  4,  1, 4,  0, 0,  32'h0,        32'h0,                          32'h0,                0,    0,    0, 1));
        tbl.push_back(mk(3,  4,  1, 3,  1, 4,  32'h44,       32'h0,                          BYP ? 32'h44 : 32'h0, 0,    !BYP, 0, 1));
        tbl.push_back(mk(3,  4,  0, 3,  0, 0,  32'h0,        32'h0,                          32'h44,               1,    0,    0, 1));
        // underflow on unreserved reg 12
        tbl.push_back(mk(12, 0,  0, 0,  1, 12, 32'hC,        BYP ? 32'hC : 32'h0,            32'h0,                0,    0,    0, 1));
        tbl.push_back(mk(12, 0,  0, 0,  0, 0,  32'h0,        32'hC,                          32'h0,                0,    0,    0, 1));
        // bypass case on reg 6
        tbl.push_back(mk(6,  0,  1, 6,  0, 0,  32'h0,        32'h0,                          32'h0,                0,    0,    0, 1));
        tbl.push_back(mk(6,  0,  0, 0,  1, 6,  32'hCAFEF00D, BYP ? 32'hCAFEF00D : 32'h0,     32'h0,                !BYP, 0,    0, 1));
        tbl.push_back(mk(6,  0,  0, 0,  0, 0,  32'h0,        32'hCAFEF00D,                   32'h0,                0,    0,    0, 1));

        // Reset held for two edges with a write and reserve pending: all outputs 0.
        rst = 1'b1;
        v = mk(5, 7, 1, 7, 1, 5, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        drive(v.i);
        sb.push_back(v.e);
        @(negedge clk);
        sample("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            sb.push_back(tbl[k].e);
            @(negedge clk);
            sample($sformatf("v%0d", k));
            @(posedge clk);
            #1;
        end

        // Async reset: reserve reg 2, then assert rst between edges.
        v = mk(2, 5, 1, 2, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(v.i);
        @(posedge clk);
        #1;
        v = mk(2, 5, 0, 2, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(v.i);
        #1;
        expect_now(32'h0, 32'hDEADBEEF, 1, 0, 0, 1);
        sample("pre_rst");
        #1 rst = 1'b1;
        #1;
        expect_now(32'h0, 32'h0, 0, 0, 0, 0);
        sample("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        v = mk(2, 6, 0, 9, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(v.i);
        #1;
        expect_now(32'h0, 32'h0, 0, 0, 0, 0);
        sample("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file with an integrated per-register scoreboard for the pipelined core.
- Generalises the current 32x32 register file in width, depth and zero-register mode.
- Adds reset, reservation counters that track outstanding writes, and busy flags the decode stage uses to detect read-after-write hazards.
- Sits between decode (reads, reservations) and writeback (writes, reservation release).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers (power of two, >= 2)
AW, $clog2(NREG), register-number width
CNTW, 2, reservation counter width; max outstanding writes per register = 2^CNTW - 1
ZERO_REG, 1, 1 = register 0 reads as zero and is never written, reserved or busy

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
srcreg1_num  input  AW  read port 1 register number
srcreg2_num  input  AW  read port 2 register number
regdata1  output  XLEN  read data 1
regdata2  output  XLEN  read data 2
src1_busy  output  1  counter of srcreg1_num is nonzero
src2_busy  output  1  counter of srcreg2_num is nonzero
rsv_we  input  1  reserve request from decode
rsv_num  input  AW  register to reserve
rsv_full  output  1  counter of rsv_num is saturated; reservation refused
dstreg_num  input  AW  writeback register number
write_value  input  XLEN  writeback data
reg_we  input  1  writeback enable; also releases one reservation
busy_cnt  output  1  number of registers with nonzero counter exceeds 0 (pipeline-drain indicator)

Behaviour:
Reset:
- rst asserted clears all registers and all counters asynchronously.
- While in reset, regdata1/2 = 0, src1/2_busy = 0, rsv_full = 0 and busy_cnt = 0.
- Reset asserted mid-operation discards all pending reservations. Writes in flight are lost.

Reads:
- Combinational, zero-latency.
- With ZERO_REG=1, register 0 always reads 0.

Writes:
- Register dstreg_num is updated at posedge clk when reg_we=1.
- With ZERO_REG=1, writes to register 0 are dropped and leave its counter at 0.

Counters (one CNTW-bit counter per register, updated at posedge):
- Reserve accepted when rsv_we=1 and rsv_full=0 (and rsv_num!=0 if ZERO_REG): counter[rsv_num] +1.
- Release when reg_we=1: counter[dstreg_num] -1. A release on a counter already at 0 is held at 0, with no underflow.
- Reserve and release on the same register in the same cycle: counter unchanged. A saturated counter is still released by the writeback, and the reserve is refused.
- Reserve and release on different registers: both applied.
- rsv_full = (counter[rsv_num] == 2^CNTW-1), combinational. A refused reservation changes no state. Decode must stall and retry.

Busy flags:
- srcN_busy = counter[srcregN_num] != 0, combinational from the current counter.
- A same-cycle writeback does not clear busy until the next cycle, unless bypass is enabled (see below).
- busy_cnt = OR of all counters nonzero.

Optional Feature:
Macro: REGFILE_WB_BYPASS_EN

Defined:
- When reg_we=1 and dstreg_num == srcregN_num (and that register is nonzero under ZERO_REG), regdataN = write_value in the same cycle.
- srcN_busy is evaluated on the counter after the pending release. It is deasserted if that counter would reach 0 this edge, and a same-cycle reserve to that register is ignored for this check.

Undefined:
- Reads return stored contents only.
- Busy flags come from stored counters only.
- Write data becomes visible one cycle after the write.

Test Plan:
1. Reset then read: assert rst for 2 cycles, release, read regs 0 and 31 -> both 0x00000000; all busy = 0; busy_cnt = 0.
2. Write/read with zero register: write 0xDEADBEEF to reg 5 and 0x12345678 to reg 0 -> regdata1(5) = 0xDEADBEEF next cycle; regdata2(0) = 0; rsv_num = 0 never sets busy.
3. Reservation lifecycle: reserve reg 7 three times -> rsv_full = 1 on the 4th request and the counter stays at 3. Three writebacks to 7 -> src1_busy drops after the 3rd edge; busy_cnt goes to 0.
4. Simultaneous events: counter[9] = 1, rsv_we + reg_we on reg 9 in the same cycle -> counter stays 1, busy stays 1. Reserve reg 3 with release on reg 4 -> both counters updated.
5. Underflow and async reset: writeback to unreserved reg 12 -> counter stays 0. Reserve reg 2, assert rst mid-cycle (between edges) -> src busy = 0 immediately, without waiting for a clock edge.
6. Bypass (macro defined): counter[6] = 1, reg_we with 0xCAFEF00D to reg 6 while srcreg1_num = 6 -> regdata1 = 0xCAFEF00D and src1_busy = 0 in the same cycle. With the macro undefined -> old value and busy = 1 for that cycle.
